// File: rtl/axi_tlb_l1_mc_pkg.sv
// Shared types for the axi_tlb_l1_mc translation table.
//   flags_t        : per-entry permission/valid flags, packed MSB-first as
//                    {writable, readable, valid}
//   commit_state_e : state of the shadow-to-active commit machine
package axi_tlb_l1_mc_pkg;

    typedef struct packed {
        logic writable;
        logic readable;
        logic valid;
    } flags_t;

    localparam int FlagsW = $bits(flags_t);

    typedef enum logic {
        CMT_IDLE = 1'b0,
        CMT_PEND = 1'b1
    } commit_state_e;

endpackage

// File: rtl/axi_tlb_l1_mc_chan.sv
// One request/result channel of axi_tlb_l1_mc.
// Looks the request address up in the flattened active table (lowest index
// wins), registers the result in a one-deep output stage and keeps a
// saturating miss counter.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   busy_i              : commit pending, blocks new requests
//   table_i             : active table, entry e at [e*EntryW +: EntryW]
//   req_addr_i/valid_i/ready_o  : request handshake
//   res_hit_o/addr_o/valid_o/ready_i : result handshake
//   miss_clr_i          : clear miss counter (wins over increment)
//   miss_cnt_o          : saturating miss count
module axi_tlb_l1_mc_chan
    import axi_tlb_l1_mc_pkg::*;
#(
    parameter int InpAddrWidth    = 48,
    parameter int OupAddrWidth    = 48,
    parameter int PageOffsetWidth = 12,
    parameter int NumEntries      = 4,
    parameter int CntWidth        = 16,
    parameter bit IsWrite         = 1'b0,
    localparam int IpW    = InpAddrWidth - PageOffsetWidth,
    localparam int OpW    = OupAddrWidth - PageOffsetWidth,
    localparam int EntryW = 2 * IpW + OpW + FlagsW
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         busy_i,
    input  logic [NumEntries*EntryW-1:0] table_i,
    input  logic [InpAddrWidth-1:0]      req_addr_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    output logic                         res_hit_o,
    output logic [OupAddrWidth-1:0]      res_addr_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    input  logic                         miss_clr_i,
    output logic [CntWidth-1:0]          miss_cnt_o
);

    typedef struct packed {
        flags_t         flags;
        logic [OpW-1:0] base;
        logic [IpW-1:0] last;
        logic [IpW-1:0] first;
    } entry_t;

    logic [IpW-1:0]             page;
    logic [PageOffsetWidth-1:0] offset;
    logic [NumEntries-1:0]      match;
    logic [OpW-1:0]             xlat_page [NumEntries];

    assign page   = req_addr_i[InpAddrWidth-1:PageOffsetWidth];
    assign offset = req_addr_i[PageOffsetWidth-1:0];

    generate
        for (genvar gi = 0; gi < NumEntries; gi++) begin : g_entry
            entry_t ent;
            logic   perm;
            assign ent  = entry_t'(table_i[gi*EntryW +: EntryW]);
            assign perm = IsWrite ? ent.flags.writable : ent.flags.readable;
            assign match[gi] = ent.flags.valid & perm
                             & (page >= ent.first) & (page <= ent.last);
            // Modular page arithmetic: resizing both operands to OpW first
            // gives the same result as a wide sum truncated to OpW.
            assign xlat_page[gi] = OpW'(page) - OpW'(ent.first) + ent.base;
        end
    endgenerate

    // Priority select: iterate high to low so the lowest match overrides.
    logic           lk_hit;
    logic [OpW-1:0] lk_page;
    always_comb begin
        lk_hit  = 1'b0;
        lk_page = '0;
        for (int e = NumEntries - 1; e >= 0; e--) begin
            if (match[e]) begin
                lk_hit  = 1'b1;
                lk_page = xlat_page[e];
            end
        end
    end

    logic                    valid_q, valid_d;
    logic                    hit_q, hit_d;
    logic [OupAddrWidth-1:0] addr_q, addr_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    accept;

    assign req_ready_o = ~busy_i & (~valid_q | res_ready_i);
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        valid_d = valid_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        if (accept) begin
            valid_d = 1'b1;
            hit_d   = lk_hit;
            addr_d  = lk_hit ? {lk_page, offset} : '0;
        end else if (res_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (miss_clr_i) begin
            cnt_d = '0;
        end else if (accept && !lk_hit && !(&cnt_q)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_valid_o = valid_q;
    assign res_hit_o   = hit_q;
    assign res_addr_o  = addr_q;
    assign miss_cnt_o  = cnt_q;

endmodule

// File: rtl/axi_tlb_l1_mc.sv
// Multi-channel L1 range translation table.
// Holds a shadow table written through the cfg port and an active table used
// by all channels. A commit copies shadow to active once every channel's
// result register is empty; new requests are blocked while it is pending.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   req_addr_i/valid_i/ready_o        : per-channel requests (flattened)
//   res_hit_o/addr_o/valid_o/ready_i  : per-channel results (flattened)
//   cfg_we_i, cfg_idx_i, cfg_entry_i  : shadow entry write
//   cfg_commit_i, cfg_busy_o          : commit request / pending
//   miss_cnt_o, miss_clr_i            : per-channel miss counters
module axi_tlb_l1_mc
    import axi_tlb_l1_mc_pkg::*;
#(
    parameter int                  InpAddrWidth    = 48,
    parameter int                  OupAddrWidth    = 48,
    parameter int                  PageOffsetWidth = 12,
    parameter int                  NumEntries      = 4,
    parameter int                  NumChans        = 2,
    parameter logic [NumChans-1:0] ChanIsWrite     = 2'b01,
    parameter int                  CntWidth        = 16,
    localparam int IpW    = InpAddrWidth - PageOffsetWidth,
    localparam int OpW    = OupAddrWidth - PageOffsetWidth,
    localparam int IdxW   = (NumEntries > 1) ? $clog2(NumEntries) : 1,
    localparam int EntryW = 2 * IpW + OpW + FlagsW
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumChans*InpAddrWidth-1:0] req_addr_i,
    input  logic [NumChans-1:0]              req_valid_i,
    output logic [NumChans-1:0]              req_ready_o,
    output logic [NumChans-1:0]              res_hit_o,
    output logic [NumChans*OupAddrWidth-1:0] res_addr_o,
    output logic [NumChans-1:0]              res_valid_o,
    input  logic [NumChans-1:0]              res_ready_i,
    input  logic                             cfg_we_i,
    input  logic [IdxW-1:0]                  cfg_idx_i,
    input  logic [EntryW-1:0]                cfg_entry_i,
    input  logic                             cfg_commit_i,
    output logic                             cfg_busy_o,
    output logic [NumChans*CntWidth-1:0]     miss_cnt_o,
    input  logic                             miss_clr_i
);

    typedef struct packed {
        flags_t         flags;
        logic [OpW-1:0] base;
        logic [IpW-1:0] last;
        logic [IpW-1:0] first;
    } entry_t;

    commit_state_e state_q, state_d;
    logic          busy;
    logic          load_active;
    logic          shadow_we;

    assign busy       = (state_q == CMT_PEND);
    assign cfg_busy_o = busy;
    // Writes during a pending commit are dropped so the committed image is
    // exactly what software had staged when it asked for the commit.
    assign shadow_we  = cfg_we_i & ~busy;

    always_comb begin
        state_d     = state_q;
        load_active = 1'b0;
        case (state_q)
            CMT_IDLE: begin
                if (cfg_commit_i) begin
                    state_d = CMT_PEND;
                end
            end
            CMT_PEND: begin
                // No request can be accepted here, so once every result has
                // drained the active table can be swapped without any
                // in-flight result mixing old and new mappings.
                if (!(|res_valid_o)) begin
                    state_d     = CMT_IDLE;
                    load_active = 1'b1;
                end
            end
            default: state_d = CMT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CMT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    entry_t                       shadow_q [NumEntries];
    entry_t                       active_q [NumEntries];
    logic [NumEntries*EntryW-1:0] active_flat;

    // Index decode per entry: an out-of-range index matches no entry.
    generate
        for (genvar gi = 0; gi < NumEntries; gi++) begin : g_table
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    shadow_q[gi] <= '0;
                end else if (shadow_we && (cfg_idx_i == IdxW'(gi))) begin
                    shadow_q[gi] <= entry_t'(cfg_entry_i);
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    active_q[gi] <= '0;
                end else if (load_active) begin
                    active_q[gi] <= shadow_q[gi];
                end
            end

            assign active_flat[gi*EntryW +: EntryW] = active_q[gi];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NumChans; gi++) begin : g_chan
            axi_tlb_l1_mc_chan #(
                .InpAddrWidth   (InpAddrWidth),
                .OupAddrWidth   (OupAddrWidth),
                .PageOffsetWidth(PageOffsetWidth),
                .NumEntries     (NumEntries),
                .CntWidth       (CntWidth),
                .IsWrite        (ChanIsWrite[gi])
            ) u_chan (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .busy_i     (busy),
                .table_i    (active_flat),
                .req_addr_i (req_addr_i[gi*InpAddrWidth +: InpAddrWidth]),
                .req_valid_i(req_valid_i[gi]),
                .req_ready_o(req_ready_o[gi]),
                .res_hit_o  (res_hit_o[gi]),
                .res_addr_o (res_addr_o[gi*OupAddrWidth +: OupAddrWidth]),
                .res_valid_o(res_valid_o[gi]),
                .res_ready_i(res_ready_i[gi]),
                .miss_clr_i (miss_clr_i),
                .miss_cnt_o (miss_cnt_o[gi*CntWidth +: CntWidth])
            );
        end
    endgenerate

endmodule

// File: tb/tb_axi_tlb_l1_mc.sv
module tb_axi_tlb_l1_mc;

    localparam int IAW  = 48;
    localparam int OAW  = 40;
    localparam int POW  = 12;
    localparam int NE   = 4;
    localparam int NC   = 2;
    localparam int CW   = 2;
    localparam int IPW  = IAW - POW;
    localparam int OPW  = OAW - POW;
    localparam int IDXW = 2;
    localparam int EW   = 2 * IPW + OPW + 3;
    localparam logic [NC-1:0] CHW = 2'b01;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*IAW-1:0] req_addr;
    logic [NC-1:0]     req_valid, req_ready, res_hit, res_valid, res_ready;
    logic [NC*OAW-1:0] res_addr;
    logic              cfg_we, cfg_commit, cfg_busy, miss_clr;
    logic [IDXW-1:0]   cfg_idx;
    logic [EW-1:0]     cfg_entry;
    logic [NC*CW-1:0]  miss_cnt;

    always #5 clk = ~clk;

    axi_tlb_l1_mc #(
        .InpAddrWidth(IAW), .OupAddrWidth(OAW), .PageOffsetWidth(POW),
        .NumEntries(NE), .NumChans(NC), .ChanIsWrite(CHW), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .res_hit_o(res_hit), .res_addr_o(res_addr), .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_entry_i(cfg_entry),
        .cfg_commit_i(cfg_commit), .cfg_busy_o(cfg_busy),
        .miss_cnt_o(miss_cnt), .miss_clr_i(miss_clr)
    );

    typedef struct {
        logic [IPW-1:0] first;
        logic [IPW-1:0] last;
        logic [OPW-1:0] base;
        logic w, r, v;
    } ment_t;

    typedef struct {
        int             chan;
        logic [IAW-1:0] addr;
        logic           hit;
        logic [OAW-1:0] exp;
    } vec_t;

    ment_t shadow_m [NE];
    ment_t active_m [NE];
    int    cnt_m [NC];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OAW-1:0] raddr(input int c);
        return res_addr[c*OAW +: OAW];
    endfunction

    function automatic int rcnt(input int c);
        return int'(miss_cnt[c*CW +: CW]);
    endfunction

    function automatic ment_t mk(input longint f, input longint l, input longint b,
                                 input logic w, input logic r, input logic v);
        ment_t e;
        e.first = IPW'(f); e.last = IPW'(l); e.base = OPW'(b);
        e.w = w; e.r = r; e.v = v;
        return e;
    endfunction

    // Reference lookup: scan entries in index order, first qualifying wins.
    function automatic void ref_lookup(input int c, input logic [IAW-1:0] a,
                                       output logic hit, output logic [OAW-1:0] oa);
        longint unsigned page, off, p;
        page = 64'(a >> POW);
        off  = 64'(a) & 64'hFFF;
        hit  = 1'b0;
        oa   = '0;
        for (int e = 0; e < NE; e++) begin
            logic perm;
            perm = CHW[c] ? active_m[e].w : active_m[e].r;
            if (!hit && active_m[e].v && perm &&
                page >= 64'(active_m[e].first) && page <= 64'(active_m[e].last)) begin
                p   = (page - 64'(active_m[e].first) + 64'(active_m[e].base)) % (64'd1 << OPW);
                hit = 1'b1;
                oa  = OAW'((p << POW) | off);
            end
        end
    endfunction

    task automatic count_miss(input int c);
        if (cnt_m[c] < CMAX) cnt_m[c]++;
    endtask

    task automatic cfg_wr(input int idx, input ment_t e);
        cfg_we    = 1'b1;
        cfg_idx   = IDXW'(idx);
        cfg_entry = {e.w, e.r, e.v, e.base, e.last, e.first};
        tick();
        cfg_we = 1'b0;
        if (idx < NE) shadow_m[idx] = e;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (cfg_busy && n < 20) begin
            tick();
            n++;
        end
        chk("commit_done", cfg_busy, 0);
    endtask

    task automatic commit();
        int n;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("busy_after_commit", cfg_busy, 1);
        wait_idle(n);
        chk("commit_min_pend", n, 1);
        active_m = shadow_m;
    endtask

    // One request on channel c with res_ready high, result checked after one edge.
    task automatic single(input string name, input int c, input logic [IAW-1:0] a,
                          input logic eh, input logic [OAW-1:0] ea);
        res_ready          = '1;
        req_addr[c*IAW +: IAW] = a;
        req_valid[c]       = 1'b1;
        #1;
        chk({name, "_rdy"}, req_ready[c], 1);
        @(posedge clk);
        #1;
        req_valid[c] = 1'b0;
        if (!eh) count_miss(c);
        chk({name, "_vld"}, res_valid[c], 1);
        chk({name, "_hit"}, res_hit[c], eh);
        chk({name, "_addr"}, raddr(c), ea);
        chk({name, "_cnt"}, rcnt(c), cnt_m[c]);
        $display("txn %s ch%0d addr=%h hit=%0d out=%h", name, c, a, res_hit[c], raddr(c));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required end of test");
        $fatal(1);
    end

    initial begin
        vec_t vecs [13];
        int   n;
        logic [IAW-1:0] cur_a;
        logic [OAW-1:0] cur_e;
        logic           acc [NC];
        logic           nh [NC];
        logic [OAW-1:0] na [NC];
        logic           mv [NC];
        logic           mh [NC];
        logic [OAW-1:0] ma [NC];

        rst = 1'b1; req_addr = '0; req_valid = '0; res_ready = '1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_entry = '0; cfg_commit = 1'b0; miss_clr = 1'b0;
        for (int e = 0; e < NE; e++) shadow_m[e] = mk(0, 0, 0, 0, 0, 0);
        active_m = shadow_m;
        for (int c = 0; c < NC; c++) cnt_m[c] = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_valid", res_valid, 0);
        chk("rst_hit", res_hit, 0);
        chk("rst_addr", res_addr, 0);
        chk("rst_ready", req_ready, 2'b11);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_cnt", miss_cnt, 0);

        // Table setup
        cfg_wr(0, mk(36'h10, 36'h1F, 28'h200, 0, 1, 1));
        cfg_wr(1, mk(36'h00, 36'hFF, 28'h1000, 1, 1, 1));
        cfg_wr(2, mk(36'h300, 36'h3FF, 28'h50, 0, 1, 1));
        cfg_wr(3, mk(36'h500, 36'h5FF, 28'hFFFFFF0, 1, 1, 1));
        commit();

        vecs[0]  = '{1, 48'h012345, 1'b1, 40'h0202345};
        vecs[1]  = '{1, 48'h015000, 1'b1, 40'h0205000};
        vecs[2]  = '{1, 48'h020000, 1'b1, 40'h1020000};
        vecs[3]  = '{0, 48'h015000, 1'b1, 40'h1015000};
        vecs[4]  = '{0, 48'h301000, 1'b0, 40'h0};
        vecs[5]  = '{1, 48'h301ABC, 1'b1, 40'h0051ABC};
        vecs[6]  = '{1, 48'h400000, 1'b0, 40'h0};
        vecs[7]  = '{0, 48'h0FF123, 1'b1, 40'h10FF123};
        vecs[8]  = '{1, 48'h100000, 1'b0, 40'h0};
        vecs[9]  = '{1, 48'h01FFFF, 1'b1, 40'h020FFFF};
        vecs[10] = '{0, 48'h520ABC, 1'b1, 40'h0010ABC};
        vecs[11] = '{1, 48'h00F000, 1'b1, 40'h100F000};
        vecs[12] = '{1, 48'h010000, 1'b1, 40'h0200000};
        for (int i = 0; i < 13; i++)
            single($sformatf("vec%0d", i), vecs[i].chan, vecs[i].addr, vecs[i].hit, vecs[i].exp);

        // Counter clear, saturation, clear-wins
        miss_clr = 1'b1; tick(); miss_clr = 1'b0;
        for (int c = 0; c < NC; c++) cnt_m[c] = 0;
        chk("clr_cnt", miss_cnt, 0);
        for (int i = 0; i < 5; i++) single($sformatf("sat%0d", i), 0, 48'h301000, 1'b0, 40'h0);
        chk("sat_value", rcnt(0), 3);
        req_addr[0 +: IAW] = 48'h301000; req_valid[0] = 1'b1; miss_clr = 1'b1;
        tick();
        req_valid[0] = 1'b0; miss_clr = 1'b0;
        for (int c = 0; c < NC; c++) cnt_m[c] = 0;
        chk("clr_wins_cnt", miss_cnt, 0);
        chk("clr_wins_hit", res_hit[0], 0);
        $display("txn clr_with_miss cnt=%h", miss_cnt);

        // Backpressure on channel 1
        tick();
        res_ready = 2'b01;
        req_addr[IAW +: IAW] = 48'h012345; req_valid[1] = 1'b1;
        #1 chk("bp_rdy0", req_ready[1], 1);
        tick();
        chk("bp_vld", res_valid[1], 1);
        req_addr[IAW +: IAW] = 48'h015000;
        #1 chk("bp_rdy_low", req_ready[1], 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_hold_vld", res_valid[1], 1);
            chk("bp_hold_addr", raddr(1), 40'h0202345);
        end
        res_ready = 2'b11;
        cur_e = 40'h0205000;
        for (int i = 0; i < 8; i++) begin
            #1 chk("stream_rdy", req_ready[1], 1);
            @(posedge clk); #1;
            chk("stream_vld", res_valid[1], 1);
            chk("stream_addr", raddr(1), cur_e);
            $display("txn stream%0d ch1 out=%h", i, raddr(1));
            cur_a = {36'h10 + 36'(i), 12'(i * 3)};
            cur_e = {28'h200 + 28'(i), 12'(i * 3)};
            req_addr[IAW +: IAW] = cur_a;
        end
        req_valid[1] = 1'b0;
        tick();
        chk("stream_end", res_valid[1], 0);

        // Commit while channel 1 is stalled; write+commit in the same cycle
        res_ready = 2'b01;
        req_addr[IAW +: IAW] = 48'h012345; req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_commit = 1'b1;
        cfg_entry = {1'b0, 1'b1, 1'b1, 28'h700, 36'h1F, 36'h10};
        shadow_m[0] = mk(36'h10, 36'h1F, 28'h700, 0, 1, 1);
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        chk("stall_busy", cfg_busy, 1);
        chk("stall_rdy", req_ready, 2'b00);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_entry = '0;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_busy_hold", cfg_busy, 1);
            chk("stall_res_hold", raddr(1), 40'h0202345);
        end
        res_ready = 2'b11;
        wait_idle(n);
        chk("drain_cycles", n, 2);
        active_m = shadow_m;
        single("new_map", 1, 48'h012345, 1'b1, 40'h0702345);
        single("dropped_we", 1, 48'h020000, 1'b1, 40'h1020000);
        commit();
        single("dropped_we2", 1, 48'h020000, 1'b1, 40'h1020000);

        // Reset with held result, pending commit and a nonzero counter
        single("pre_rst_miss", 0, 48'h301000, 1'b0, 40'h0);
        res_ready = 2'b01;
        req_addr[IAW +: IAW] = 48'h012345; req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        cfg_wr(0, mk(36'h10, 36'h1F, 28'h900, 1, 1, 1));
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        chk("pre_rst_busy", cfg_busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        res_ready = 2'b11;
        chk("mrst_valid", res_valid, 0);
        chk("mrst_busy", cfg_busy, 0);
        chk("mrst_cnt", miss_cnt, 0);
        chk("mrst_rdy", req_ready, 2'b11);
        for (int e = 0; e < NE; e++) shadow_m[e] = mk(0, 0, 0, 0, 0, 0);
        active_m = shadow_m;
        for (int c = 0; c < NC; c++) cnt_m[c] = 0;
        single("post_rst", 1, 48'h012345, 1'b0, 40'h0);
        commit();
        single("post_rst_commit", 1, 48'h012345, 1'b0, 40'h0);

        // Randomised traffic against the reference model
        for (int e = 0; e < NE; e++) begin
            int f;
            f = $urandom_range(0, 63);
            cfg_wr(e, mk(f, f + $urandom_range(0, 31), $urandom, $urandom_range(0, 1),
                         $urandom_range(0, 1), ($urandom_range(0, 3) != 0)));
        end
        commit();
        for (int c = 0; c < NC; c++) mv[c] = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            miss_clr = ($urandom_range(0, 31) == 0);
            for (int c = 0; c < NC; c++) begin
                logic [IPW-1:0] pg;
                pg = IPW'($urandom_range(0, 79));
                if ($urandom_range(0, 7) == 0) pg[IPW-1] = 1'b1;
                req_addr[c*IAW +: IAW] = {pg, 12'($urandom)};
                req_valid[c] = ($urandom_range(0, 3) != 0);
                res_ready[c] = ($urandom_range(0, 2) != 0);
            end
            #1;
            for (int c = 0; c < NC; c++) begin
                chk("rnd_rdy", req_ready[c], (!mv[c] || res_ready[c]));
                acc[c] = req_valid[c] && (!mv[c] || res_ready[c]);
                ref_lookup(c, req_addr[c*IAW +: IAW], nh[c], na[c]);
            end
            @(posedge clk); #1;
            for (int c = 0; c < NC; c++) begin
                if (acc[c]) begin
                    mv[c] = 1'b1; mh[c] = nh[c]; ma[c] = na[c];
                end else if (res_ready[c]) begin
                    mv[c] = 1'b0;
                end
                if (miss_clr) cnt_m[c] = 0;
                else if (acc[c] && !nh[c]) count_miss(c);
                chk("rnd_vld", res_valid[c], mv[c]);
                if (mv[c]) begin
                    chk("rnd_hit", res_hit[c], mh[c]);
                    chk("rnd_addr", raddr(c), ma[c]);
                end
                chk("rnd_cnt", rcnt(c), cnt_m[c]);
                if (acc[c])
                    $display("txn rnd%0d ch%0d in=%h hit=%0d out=%h", cyc, c,
                             req_addr[c*IAW +: IAW], res_hit[c], raddr(c));
            end
        end
        req_valid = '0; miss_clr = 1'b0; res_ready = '1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
